// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// The ALUOp codes below must track the values in the shared constants.vh.
package muldiv_unit_pkg;

  localparam int MD_XLEN = 32;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift rem:quo left by one,
// trial-subtract the divisor and shift in the quotient bit.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // rem_in < divisor, so the shifted remainder always fits in XLEN+1 bits
  assign rem_sh = {rem_in, quo_in[XLEN-1]};
  assign diff   = rem_sh - {1'b0, divisor};

  always_comb begin
    rem_out = rem_sh[XLEN-1:0];
    quo_out = {quo_in[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage RV32M unit: single-cycle multiplies, iterative restoring divide.
// Holds the pipeline via stall until the registered result is valid.
//   state | meaning
//   IDLE  | waiting for an M op; multiplies and divide special cases finish here
//   DIV   | one restoring step per cycle, XLEN cycles
//   FIX   | apply sign corrections, select quotient or remainder
//   DONE  | done pulse, EX advances
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      ALUOp,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem, quo, dvsr;
  logic [XLEN-1:0] rem_nx, quo_nx;
  logic            sign_q, sign_r, is_rem;

  logic            is_md, is_mul, op_signed, op_rem;
  logic            a_sx, b_sx;
  logic [XLEN-1:0] a_abs, b_abs, mul_res;
  logic signed [XLEN:0]     a_ext, b_ext;
  logic signed [2*XLEN-1:0] prod;

  assign is_md = ALUOp inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                               ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

  always_comb begin
    is_mul    = ALUOp inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
    op_signed = ALUOp inside {ALU_DIV, ALU_REM};
    op_rem    = ALUOp inside {ALU_REM, ALU_REMU};
    a_sx      = ALUOp inside {ALU_MUL, ALU_MULH, ALU_MULHSU};
    b_sx      = ALUOp inside {ALU_MUL, ALU_MULH};
  end

  // 33x33 signed product; only the low 2*XLEN bits are ever needed
  assign a_ext   = {a_sx & in_a[XLEN-1], in_a};
  assign b_ext   = {b_sx & in_b[XLEN-1], in_b};
  assign prod    = (2*XLEN)'(a_ext) * (2*XLEN)'(b_ext);
  assign mul_res = (ALUOp == ALU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign a_abs = (op_signed && in_a[XLEN-1]) ? -in_a : in_a;
  assign b_abs = (op_signed && in_b[XLEN-1]) ? -in_b : in_b;

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem),
    .quo_in  (quo),
    .divisor (dvsr),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  assign stall = reset & (((state == S_IDLE) & start & is_md) |
                          (state == S_DIV) | (state == S_FIX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      result <= '0;
      done   <= 1'b0;
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      is_rem <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && is_md) begin
              if (is_mul) begin
                result <= mul_res;
                done   <= 1'b1;
                state  <= S_DONE;
              end else if (in_b == '0) begin
                result <= op_rem ? in_a : '1;
                done   <= 1'b1;
                state  <= S_DONE;
              end else if (op_signed && in_a == INT_MIN && in_b == '1) begin
                result <= op_rem ? '0 : in_a;
                done   <= 1'b1;
                state  <= S_DONE;
              end else begin
                rem    <= '0;
                quo    <= a_abs;
                dvsr   <= b_abs;
                count  <= CW'(XLEN - 1);
                sign_q <= op_signed & (in_a[XLEN-1] ^ in_b[XLEN-1]);
                sign_r <= op_signed & in_a[XLEN-1];
                is_rem <= op_rem;
                state  <= S_DIV;
              end
            end
          end
          S_DIV: begin
            rem <= rem_nx;
            quo <= quo_nx;
            if (count == '0) state <= S_FIX;
            else             count <= count - 1'b1;
          end
          S_FIX: begin
            if (is_rem) result <= sign_r ? -rem : rem;
            else        result <= sign_q ? -quo : quo;
            done  <= 1'b1;
            state <= S_DONE;
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, stall shape, flush and reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [4:0]  ALUOp;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] result;
  logic        done;
  logic        stall;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .ALUOp  (ALUOp),
    .in_a   (in_a),
    .in_b   (in_b),
    .result (result),
    .done   (done),
    .stall  (stall)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, then check latency, stall shape and result.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int stall_lo;
    logic stall_done;
    @(negedge clock);
    ALUOp = op; in_a = a; in_b = b; start = 1'b1;
    #1 chk({tag, "_stall_accept"}, 32'(stall), 32'd1);
    @(posedge clock);
    lat = 0; stall_lo = 0; stall_done = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      start = 1'b0; ALUOp = ALU_ADD; in_a = $urandom; in_b = $urandom;
      #1;
      if (done) begin
        lat = i;
        stall_done = stall;
        break;
      end
      if (!stall) stall_lo++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_result"}, result, exp);
    chk({tag, "_stall_done"}, 32'(stall_done), 32'd0);
    chk({tag, "_stall_gaps"}, 32'(stall_lo), 32'd0);
  endtask

  initial begin
    int done_seen;
    reset = 1'b0; start = 1'b1; flush = 1'b0; ALUOp = ALU_MUL; in_a = 32'd3; in_b = 32'd4;
    #2;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;

    run_op("mul",    ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    @(negedge clock); #1 chk("mul_hold", result, 32'hFFFFFFEB);
    run_op("mulh",   ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1);
    run_op("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run_op("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    run_op("div",    ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem",    ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu",   ALU_DIVU,   32'd100,      32'd7,        32'd14,       34);
    run_op("remu",   ALU_REMU,   32'd100,      32'd7,        32'd2,        34);
    run_op("div_nd", ALU_DIV,    32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 34);
    run_op("rem_nd", ALU_REM,    32'd20,       32'hFFFFFFFA, 32'd2,        34);
    run_op("divu_max", ALU_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34);
    run_op("div_z",  ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("divu_z", ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_z", ALU_REMU,   32'd5,        32'd0,        32'd5,        1);
    run_op("div_ov", ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ov", ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // non-M op is ignored
    @(negedge clock);
    ALUOp = ALU_ADD; in_a = 32'd1; in_b = 32'd2; start = 1'b1;
    #1 chk("nonm_stall", 32'(stall), 32'd0);
    @(negedge clock);
    start = 1'b0;
    #1 chk("nonm_done", 32'(done), 32'd0);
    chk("nonm_result", result, 32'd0);

    // flush beats a same-cycle accept
    @(negedge clock);
    ALUOp = ALU_MUL; in_a = 32'd9; in_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    #1 chk("flush_acc_done", 32'(done), 32'd0);
    chk("flush_acc_stall", 32'(stall), 32'd0);
    chk("flush_acc_result", result, 32'd0);

    // flush in cycle 10 of a DIV
    @(negedge clock);
    ALUOp = ALU_DIV; in_a = 32'hFFFFFFF9; in_b = 32'd2; start = 1'b1;
    @(posedge clock);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (i == 10) flush = 1'b1;
    end
    @(negedge clock);
    flush = 1'b0;
    #1 chk("flush_div_stall", 32'(stall), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      #1 if (done) done_seen++;
    end
    chk("flush_div_nodone", 32'(done_seen), 32'd0);
    chk("flush_div_result", result, 32'd0);
    run_op("mul_after_flush", ALU_MUL, 32'd3, 32'd4, 32'd12, 1);

    // async reset mid-DIV, between edges
    @(negedge clock);
    ALUOp = ALU_DIVU; in_a = 32'd1000; in_b = 32'd3; start = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 5; i++) @(negedge clock);
    start = 1'b1; ALUOp = ALU_MUL;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;

    run_op("b2b_divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("b2b_mul",  ALU_MUL,  32'd6,   32'd7, 32'd42, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
